// File: rtl/mcu_pkg.sv
// Shared constants and types for the request encoder: request width, index width,
// grant FSM states and a one-hot helper used by the clear decode.
package mcu_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/prio_find16.sv
// Combinational wrap-around priority finder: returns the first set bit of vec_i
// at or after start_i, searching upward and wrapping from 15 back to 0.
module prio_find16
  import mcu_pkg::*;
(
  input  logic [N_REQ-1:0] vec_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  always_comb begin
    dbl     = {vec_i, vec_i};
    // rot[j] is vec_i[(start_i + j) mod 16], so the lowest set bit of rot is the winner
    rot     = dbl[start_i +: N_REQ];
    found_o = |vec_i;
    idx_o   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) idx_o = start_i + IDX_W'(j);
    end
  end

endmodule

// File: rtl/req_enc16_4.sv
// Registered 16-to-4 request encoder: sticky pending vector, fixed or rotating
// priority selection and a valid/ack grant that holds idx until consumed.
module req_enc16_4
  import mcu_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             ack,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [N_REQ-1:0] pending,
  output state_e           dbg_state
);

  // Handshake: idx is meaningful only while valid=1 and is frozen until the
  // cycle in which ack=1 is sampled with valid=1; ack while valid=0 is ignored.

  state_e           state_q;
  logic [N_REQ-1:0] pending_q, pending_d, cand, clr;
  logic [IDX_W-1:0] idx_q, last_q, start, win_idx;
  logic             valid_q, win_found;

  assign start = ROUND_ROBIN ? (last_q + IDX_W'(1)) : '0;

  always_comb begin
    cand      = pending_q & mask;
    clr       = (valid_q && ack) ? idx_onehot(idx_q) : '0;
    // a new request arriving in the ack cycle survives the clear
    pending_d = (pending_q & ~clr) | req;
  end

  prio_find16 u_find (
    .vec_i   (cand),
    .start_i (start),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= IDX_W'(N_REQ - 1);
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            idx_q   <= win_idx;
            valid_q <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (ack) begin
            valid_q <= 1'b0;
            last_q  <= idx_q;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign idx       = idx_q;
  assign valid     = valid_q;
  assign pending   = pending_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_req_enc16_4.sv
// Directed bench for req_enc16_4: one fixed-priority and one round-robin instance
// driven through reset, grant, masking, accumulation and mid-grant reset scenarios.
module tb_req_enc16_4;
  import mcu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] f_req, f_mask, r_req, r_mask;
  logic             f_ack, r_ack;
  logic [IDX_W-1:0] f_idx, r_idx;
  logic             f_valid, r_valid;
  logic [N_REQ-1:0] f_pending, r_pending;
  state_e           f_state, r_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  req_enc16_4 #(.ROUND_ROBIN(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .req(f_req), .mask(f_mask), .ack(f_ack),
    .idx(f_idx), .valid(f_valid), .pending(f_pending), .dbg_state(f_state)
  );

  req_enc16_4 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(r_req), .mask(r_mask), .ack(r_ack),
    .idx(r_idx), .valid(r_valid), .pending(r_pending), .dbg_state(r_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; f_req = '0; f_mask = '0; f_ack = 1'b0;
    r_req = '0; r_mask = '0; r_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(f_valid), 32'd0);
    chk("rst_idx", 32'(f_idx), 32'd0);
    chk("rst_pending", 32'(f_pending), 32'h0);
    chk("rst_state", 32'(f_state), 32'(IDLE));

    // single pulse, two-cycle latency
    f_req = 16'h0020; f_mask = 16'hFFFF;
    tick(); f_req = '0;
    chk("t1_pend", 32'(f_pending), 32'h0020);
    chk("t1_valid_early", 32'(f_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(f_valid), 32'd1);
    chk("t1_idx", 32'(f_idx), 32'd5);
    f_ack = 1'b1; tick(); f_ack = 1'b0;
    chk("t1_ack_valid", 32'(f_valid), 32'd0);
    chk("t1_ack_pend", 32'(f_pending), 32'h0);
    tick();
    chk("t1_idle", 32'(f_valid), 32'd0);

    // fixed priority 0, 8, 15 with bubbles
    f_req = 16'h8101;
    tick(); f_req = '0;
    tick();
    chk("t2_g0_valid", 32'(f_valid), 32'd1);
    chk("t2_g0_idx", 32'(f_idx), 32'd0);
    f_ack = 1'b1; tick(); f_ack = 1'b0;
    chk("t2_b0_valid", 32'(f_valid), 32'd0);
    chk("t2_b0_pend", 32'(f_pending), 32'h8100);
    tick();
    chk("t2_g8_valid", 32'(f_valid), 32'd1);
    chk("t2_g8_idx", 32'(f_idx), 32'd8);
    f_ack = 1'b1; tick(); f_ack = 1'b0;
    chk("t2_b1_valid", 32'(f_valid), 32'd0);
    chk("t2_b1_pend", 32'(f_pending), 32'h8000);
    tick();
    chk("t2_g15_idx", 32'(f_idx), 32'd15);
    chk("t2_g15_valid", 32'(f_valid), 32'd1);
    f_ack = 1'b1; tick(); f_ack = 1'b0;
    chk("t2_end_pend", 32'(f_pending), 32'h0);
    tick(); tick();
    chk("t2_end_valid", 32'(f_valid), 32'd0);

    // grant idx 3, mask it mid-grant, re-pulse in the ack cycle
    f_req = 16'h0008;
    tick(); f_req = '0;
    tick();
    chk("t4_idx", 32'(f_idx), 32'd3);
    f_mask = 16'hFFF7;
    tick();
    chk("t4_hold_idx", 32'(f_idx), 32'd3);
    chk("t4_hold_valid", 32'(f_valid), 32'd1);
    f_ack = 1'b1; f_req = 16'h0008;
    tick(); f_ack = 1'b0; f_req = '0;
    chk("t4_ack_valid", 32'(f_valid), 32'd0);
    chk("t4_setwins_pend", 32'(f_pending), 32'h0008);
    tick();
    chk("t4_masked_valid", 32'(f_valid), 32'd0);
    f_mask = 16'hFFFF;
    tick();
    chk("t4_regrant_valid", 32'(f_valid), 32'd1);
    chk("t4_regrant_idx", 32'(f_idx), 32'd3);
    f_ack = 1'b1; tick(); f_ack = 1'b0;
    chk("t4_end_pend", 32'(f_pending), 32'h0);

    // all masked: accumulate without granting
    f_mask = 16'h0000; f_req = 16'hFFFF;
    tick(); f_req = '0;
    tick();
    chk("t5_pend", 32'(f_pending), 32'hFFFF);
    tick(); tick(); tick();
    chk("t5_no_valid", 32'(f_valid), 32'd0);
    f_mask = 16'h0400;
    tick();
    chk("t5_valid", 32'(f_valid), 32'd1);
    chk("t5_idx", 32'(f_idx), 32'd10);
    f_ack = 1'b1; tick(); f_ack = 1'b0;
    chk("t5_pend_after", 32'(f_pending), 32'hFBFF);

    // reset during a grant of idx 7, then ack while idle
    f_mask = 16'h0080;
    tick();
    chk("t6_valid", 32'(f_valid), 32'd1);
    chk("t6_idx", 32'(f_idx), 32'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_valid", 32'(f_valid), 32'd0);
    chk("t6_rst_idx", 32'(f_idx), 32'd0);
    chk("t6_rst_pend", 32'(f_pending), 32'h0);
    f_ack = 1'b1; tick(); tick(); f_ack = 1'b0;
    chk("t6_idle_ack_valid", 32'(f_valid), 32'd0);
    chk("t6_idle_ack_pend", 32'(f_pending), 32'h0);
    chk("t6_idle_ack_idx", 32'(f_idx), 32'd0);
    chk("t6_idle_ack_state", 32'(f_state), 32'(IDLE));

    // round robin with req held at 0x0011 and ack held high
    r_mask = 16'hFFFF; r_req = 16'h0011; r_ack = 1'b1;
    tick();
    chk("rr_pend", 32'(r_pending), 32'h0011);
    tick();
    chk("rr_g1_valid", 32'(r_valid), 32'd1);
    chk("rr_g1_idx", 32'(r_idx), 32'd0);
    tick();
    chk("rr_b1_valid", 32'(r_valid), 32'd0);
    chk("rr_b1_pend", 32'(r_pending), 32'h0011);
    tick();
    chk("rr_g2_idx", 32'(r_idx), 32'd4);
    tick(); tick();
    chk("rr_g3_idx", 32'(r_idx), 32'd0);
    tick(); tick();
    chk("rr_g4_idx", 32'(r_idx), 32'd4);
    chk("rr_g4_valid", 32'(r_valid), 32'd1);
    r_req = '0; r_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
